// File: rtl/pixel_write_queue.sv
// pixel_write_queue: small FIFO between the box-drawing stage and the
// video-memory write port. Requests carry (X, Y, colour); the linear
// address is formed at enqueue time so the head entry drives oAddr directly.
module pixel_write_queue #(
  parameter int X_SCREENSIZE = 160,
  parameter int Y_SCREENSIZE = 120,
  parameter int DEPTH        = 8
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic [7:0]               iX,
  input  logic [6:0]               iY,
  input  logic [2:0]               iColour,
  input  logic                     iPlot,
  input  logic                     iMemReady,
  output logic [14:0]              oAddr,
  output logic [2:0]               oData,
  output logic                     oWrite,
  output logic                     oFull,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oOverflow,
  output logic                     oRangeErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Linear address Y*width + X, kept at full 15-bit width (max 19199 at 160x120).
  function automatic logic [14:0] linear_addr(input logic [7:0] x, input logic [6:0] y);
    return 15'(y) * 15'(X_SCREENSIZE) + 15'(x);
  endfunction

  // Entry storage carries no reset: contents only matter while counted.
  logic [14:0]   addr_mem_q   [DEPTH];
  logic [2:0]    colour_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          range_err_q, range_err_d;

  logic          in_range;
  logic          req_valid;
  logic          full;
  logic          pop;
  logic          push;
  logic [14:0]   pix_addr;

  // Request qualification, push/pop decisions and next-state for control.
  always_comb begin
    in_range    = ({1'b0, iX} < 9'(X_SCREENSIZE)) && ({1'b0, iY} < 8'(Y_SCREENSIZE));
    req_valid   = iPlot && in_range;
    full        = (count_q == CW'(DEPTH));
    pop         = (count_q != '0) && iMemReady;
    // A full queue can still accept when the head leaves in the same cycle.
    push        = req_valid && (!full || pop);
    pix_addr    = linear_addr(iX, iY);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    range_err_d = range_err_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (req_valid && full && !pop) overflow_d  = 1'b1;
    if (iPlot && !in_range)        range_err_d = 1'b1;
  end

  // Control state: reset wins over any simultaneous push or pop.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      range_err_q <= range_err_d;
    end
  end

  // Entry write at the tail; no bypass, so a new entry shows up next cycle.
  always_ff @(posedge iClock) begin
    if (push) begin
      addr_mem_q[wr_ptr_q]   <= pix_addr;
      colour_mem_q[wr_ptr_q] <= iColour;
    end
  end

  assign oAddr     = addr_mem_q[rd_ptr_q];
  assign oData     = colour_mem_q[rd_ptr_q];
  assign oWrite    = (count_q != '0);
  assign oFull     = full;
  assign oCount    = count_q;
  assign oOverflow = overflow_q;
  assign oRangeErr = range_err_q;

endmodule
